fp_div_sqrt_iter_unit: RTL and testbench

//  Parametrised iterative radix-2 IEEE-754 divide / square-root unit with all five rounding modes and RISC-V fflags.

---
 rtl/fp_div_sqrt_iter_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_fp_div_sqrt_iter_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_div_sqrt_iter_unit.sv
// Iterative radix-2 restoring IEEE-754 divide / square root with RISC-V fflags, one op in flight.
// IDLE -> PREP -> ITER (QUO_W cycles) -> ROUND -> IDLE; special operands go PREP -> ROUND.
module fp_div_sqrt_iter_unit #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  output logic                  ready,
  input  logic                  is_divide,
  input  logic [EXP_W+MANT_W:0] lhs,
  input  logic [EXP_W+MANT_W:0] rhs,
  input  logic [2:0]            round_mode,
  input  logic                  flush,
  output logic                  done,
  output logic [EXP_W+MANT_W:0] result,
  output logic [4:0]            fflags
);
  localparam int FP_W  = 1 + EXP_W + MANT_W;
  localparam int QUO_W = MANT_W + 3;
  localparam int REM_W = MANT_W + 4;
  localparam int VE_W  = EXP_W + 2;
  localparam int CNT_W = $clog2(QUO_W + 1);
  localparam logic [VE_W-1:0] BIAS = VE_W'((1 << (EXP_W - 1)) - 1);
  localparam logic [VE_W-1:0] EMAX = VE_W'((1 << EXP_W) - 1);
  localparam logic [FP_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, ITER, ROUND} state_t;
  state_t state, state_nx;

  logic [FP_W-1:0]    a_q, b_q, spc_res_q, spc_res;
  logic [4:0]         spc_flg_q, spc_flg;
  logic               div_q, sign, special, spc;
  logic [2:0]         rm_q;
  logic [VE_W-1:0]    vexp;
  logic [QUO_W-1:0]   quo;
  logic [REM_W-1:0]   rem;
  logic [MANT_W:0]    dsr;
  logic [2*QUO_W-1:0] rad;
  logic [CNT_W-1:0]   cnt;

  function automatic logic [VE_W-1:0] lzc(input logic [MANT_W:0] v);
    logic [VE_W-1:0] n;
    logic hit;
    n = '0;
    hit = 1'b0;
    for (int i = MANT_W; i >= 0; i--) begin
      if (!hit && !v[i]) n = n + VE_W'(1);
      else hit = 1'b1;
    end
    return n;
  endfunction

  // st carries round bit OR sticky; lsb only matters for ties-to-even.
  function automatic logic rnd_inc(input logic [2:0] rm, input logic sgn, input logic lsb,
                                   input logic g, input logic st);
    case (rm)
      3'd1:    return 1'b0;
      3'd2:    return sgn & (g | st);
      3'd3:    return ~sgn & (g | st);
      3'd4:    return g;
      default: return g & (st | lsb);
    endcase
  endfunction

  logic              s_a, s_b;
  logic [EXP_W-1:0]  e_a, e_b;
  logic [MANT_W-1:0] f_a, f_b;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [MANT_W:0]   m_a, m_b, mn_a, mn_b;
  logic [VE_W-1:0]   lz_a, lz_b, x_a, x_b, ux_a, vexp_div, vexp_sqrt;
  logic              a_lt_b;
  logic [MANT_W+1:0] dividend;
  logic [2*QUO_W-1:0] rad_init;

  assign {s_a, e_a, f_a} = a_q;
  assign {s_b, e_b, f_b} = b_q;
  assign a_zero = (e_a == '0) && (f_a == '0);
  assign b_zero = (e_b == '0) && (f_b == '0);
  assign a_inf  = (&e_a) && (f_a == '0);
  assign b_inf  = (&e_b) && (f_b == '0);
  assign a_nan  = (&e_a) && (f_a != '0);
  assign b_nan  = (&e_b) && (f_b != '0);
  assign a_snan = a_nan && !f_a[MANT_W-1];
  assign b_snan = b_nan && !f_b[MANT_W-1];

  // Subnormals become 1.f with a (possibly negative) virtual exponent.
  assign m_a  = {|e_a, f_a};
  assign m_b  = {|e_b, f_b};
  assign lz_a = lzc(m_a);
  assign lz_b = lzc(m_b);
  assign mn_a = m_a << lz_a;
  assign mn_b = m_b << lz_b;
  assign x_a  = VE_W'(e_a) + VE_W'(e_a == '0) - lz_a;
  assign x_b  = VE_W'(e_b) + VE_W'(e_b == '0) - lz_b;

  assign a_lt_b    = mn_a < mn_b;
  assign vexp_div  = x_a - x_b + BIAS - VE_W'(a_lt_b);
  assign dividend  = a_lt_b ? {mn_a, 1'b0} : {1'b0, mn_a};
  assign ux_a      = x_a - BIAS;
  assign vexp_sqrt = {ux_a[VE_W-1], ux_a[VE_W-1:1]} + BIAS;
  assign rad_init  = ux_a[0] ? {mn_a, {(2*QUO_W-MANT_W-1){1'b0}}}
                             : {1'b0, mn_a, {(2*QUO_W-MANT_W-2){1'b0}}};

  always_comb begin
    spc     = 1'b0;
    spc_res = '0;
    spc_flg = '0;
    if (div_q) begin
      if (a_nan || b_nan) begin
        spc = 1'b1; spc_res = QNAN; spc_flg[4] = a_snan | b_snan;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
        spc = 1'b1; spc_res = QNAN; spc_flg[4] = 1'b1;
      end else if (a_inf) begin
        spc = 1'b1; spc_res = {s_a ^ s_b, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      end else if (b_zero) begin
        spc = 1'b1; spc_res = {s_a ^ s_b, {EXP_W{1'b1}}, {MANT_W{1'b0}}}; spc_flg[3] = 1'b1;
      end else if (a_zero || b_inf) begin
        spc = 1'b1; spc_res = {s_a ^ s_b, {(FP_W-1){1'b0}}};
      end
    end else begin
      if (a_nan) begin
        spc = 1'b1; spc_res = QNAN; spc_flg[4] = a_snan;
      end else if (a_zero) begin
        spc = 1'b1; spc_res = {s_a, {(FP_W-1){1'b0}}};
      end else if (s_a) begin
        spc = 1'b1; spc_res = QNAN; spc_flg[4] = 1'b1;
      end else if (a_inf) begin
        spc = 1'b1; spc_res = {1'b0, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      end
    end
  end

  logic               div_bit, sq_bit;
  logic [REM_W-1:0]   div_diff, div_rem_nx, sq_rem_nx;
  logic [REM_W+1:0]   sq_t, sq_trial;

  assign div_bit    = rem >= REM_W'(dsr);
  assign div_diff   = rem - REM_W'(dsr);
  assign div_rem_nx = div_bit ? (div_diff << 1) : (rem << 1);
  assign sq_t       = {rem, rad[2*QUO_W-1 -: 2]};
  assign sq_trial   = (REM_W+2)'({quo, 2'b01});
  assign sq_bit     = sq_t >= sq_trial;
  assign sq_rem_nx  = sq_bit ? REM_W'(sq_t - sq_trial) : REM_W'(sq_t);

  logic               sticky, is_sub, lost, st_all, g, rb, inc, nx, ovf, tiny, uf, to_max, carry_n;
  logic [VE_W-1:0]    sh_full, sh, exp_r;
  logic [QUO_W-1:0]   shifted;
  logic [MANT_W:0]    kept;
  logic [MANT_W+1:0]  mant_r;
  logic [FP_W-1:0]    rnd_res;
  logic [4:0]         rnd_flg;

  assign sticky  = |rem;
  assign is_sub  = vexp[VE_W-1] || (vexp == '0);
  assign sh_full = VE_W'(1) - vexp;
  assign sh      = !is_sub ? '0 : (sh_full > VE_W'(QUO_W) ? VE_W'(QUO_W) : sh_full);
  assign shifted = quo >> sh;
  assign lost    = |(quo & ~({QUO_W{1'b1}} << sh));
  assign st_all  = sticky | lost;
  assign kept    = shifted[QUO_W-1:2];
  assign g       = shifted[1];
  assign rb      = shifted[0];
  assign inc     = rnd_inc(rm_q, sign, kept[0], g, rb | st_all);
  assign mant_r  = {1'b0, kept} + (MANT_W+2)'(inc);
  assign nx      = g | rb | st_all;
  assign exp_r   = is_sub ? VE_W'(mant_r[MANT_W]) : vexp + VE_W'(mant_r[MANT_W+1]);
  assign ovf     = !is_sub && (exp_r >= EMAX);
  // Tininess is judged on the unbounded-exponent rounding of the full-precision quotient.
  assign carry_n = rnd_inc(rm_q, sign, quo[2], quo[1], quo[0] | sticky) && (&quo[QUO_W-1:2]);
  assign tiny    = vexp[VE_W-1] || ((vexp == '0) && !carry_n);
  assign uf      = tiny && nx;
  assign to_max  = (rm_q == 3'd1) || (rm_q == 3'd2 && !sign) || (rm_q == 3'd3 && sign);
  assign rnd_res = !ovf   ? {sign, exp_r[EXP_W-1:0], mant_r[MANT_W-1:0]}
                 : to_max ? {sign, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}}
                 :          {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
  assign rnd_flg = ovf ? 5'b00101 : {3'b000, uf, nx};

  assign ready = (state == IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req && !flush) state_nx = PREP;
      PREP:    state_nx = spc ? ROUND : ITER;
      ITER:    if (cnt == CNT_W'(QUO_W - 1)) state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush && state != IDLE) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0; b_q <= '0; div_q <= 1'b0; rm_q <= '0;
      sign <= 1'b0; vexp <= '0; quo <= '0; rem <= '0; dsr <= '0; rad <= '0; cnt <= '0;
      special <= 1'b0; spc_res_q <= '0; spc_flg_q <= '0;
      done <= 1'b0; result <= '0; fflags <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: if (req && !flush) begin
          a_q <= lhs; b_q <= rhs; div_q <= is_divide; rm_q <= round_mode;
        end
        PREP: begin
          sign      <= div_q ? (s_a ^ s_b) : s_a;
          vexp      <= div_q ? vexp_div : vexp_sqrt;
          rem       <= div_q ? REM_W'(dividend) : '0;
          dsr       <= mn_b;
          rad       <= rad_init;
          quo       <= '0;
          cnt       <= '0;
          special   <= spc;
          spc_res_q <= spc_res;
          spc_flg_q <= spc_flg;
        end
        ITER: begin
          quo <= {quo[QUO_W-2:0], div_q ? div_bit : sq_bit};
          rem <= div_q ? div_rem_nx : sq_rem_nx;
          rad <= rad << 2;
          cnt <= cnt + CNT_W'(1);
        end
        ROUND: if (!flush) begin
          done   <= 1'b1;
          result <= special ? spc_res_q : rnd_res;
          fflags <= special ? spc_flg_q : rnd_flg;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_sqrt_iter_unit.sv
// Directed-vector bench for fp_div_sqrt_iter_unit: single-precision unit plus a double-precision build.
// Latency counts clock edges inclusive of the accepting edge up to the edge that raises done.
module tb_fp_div_sqrt_iter_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, ready, is_divide, flush, done;
  logic [31:0] lhs, rhs, result;
  logic [2:0]  round_mode;
  logic [4:0]  fflags;

  logic        req_d, ready_d, is_divide_d, flush_d, done_d;
  logic [63:0] lhs_d, rhs_d, result_d;
  logic [2:0]  round_mode_d;
  logic [4:0]  fflags_d;

  int n_cmp = 0;
  int n_err = 0;

  fp_div_sqrt_iter_unit dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .is_divide(is_divide),
    .lhs(lhs), .rhs(rhs), .round_mode(round_mode), .flush(flush),
    .done(done), .result(result), .fflags(fflags)
  );

  fp_div_sqrt_iter_unit #(.EXP_W(11), .MANT_W(52)) dut64 (
    .clk(clk), .rst(rst), .req(req_d), .ready(ready_d), .is_divide(is_divide_d),
    .lhs(lhs_d), .rhs(rhs_d), .round_mode(round_mode_d), .flush(flush_d),
    .done(done_d), .result(result_d), .fflags(fflags_d)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the accepting edge.
  task automatic start32(input logic div, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm);
    req = 1'b1; is_divide = div; lhs = a; rhs = b; round_mode = rm;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic collect32(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op32(input string tag, input logic div, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] rm, input logic [31:0] exp_res, input logic [4:0] exp_fl,
                      input int exp_lat);
    int lat;
    @(negedge clk);
    start32(div, a, b, rm);
    collect32(lat);
    check({tag, ".res"}, result, exp_res);
    check({tag, ".flags"}, fflags, exp_fl);
    check({tag, ".lat"}, lat, exp_lat);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; req = 1'b0; is_divide = 1'b0; lhs = '0; rhs = '0; round_mode = '0; flush = 1'b0;
    req_d = 1'b0; is_divide_d = 1'b0; lhs_d = '0; rhs_d = '0; round_mode_d = '0; flush_d = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.ready", ready, 1'b1);
    check("reset.done", done, 1'b0);
    check("reset.result", result, 32'h0);
    check("reset.flags", fflags, 5'h0);

    op32("div6_2",     1'b1, 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, 29);
    op32("div1_3rne",  1'b1, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01, 29);
    op32("div1_3rtz",  1'b1, 32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'h01, 29);
    op32("div1_3rdn",  1'b1, 32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'h01, 29);
    op32("divm1_3rdn", 1'b1, 32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'h01, 29);
    op32("div1_3rup",  1'b1, 32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'h01, 29);
    op32("sqrt2",      1'b0, 32'h40000000, 32'h0,        3'd0, 32'h3FB504F3, 5'h01, 29);
    op32("sqrt4",      1'b0, 32'h40800000, 32'h0,        3'd0, 32'h40000000, 5'h00, 29);
    op32("sqrtneg",    1'b0, 32'hBF800000, 32'h0,        3'd0, 32'h7FC00000, 5'h10, 3);
    op32("sqrtnegz",   1'b0, 32'h80000000, 32'h0,        3'd0, 32'h80000000, 5'h00, 3);
    op32("div_by0",    1'b1, 32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'h08, 3);
    op32("inf_inf",    1'b1, 32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 5'h10, 3);
    op32("snan",       1'b1, 32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h10, 3);
    op32("qnan",       1'b1, 32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h00, 3);
    op32("zero_x",     1'b1, 32'h00000000, 32'hC0000000, 3'd0, 32'h80000000, 5'h00, 3);
    op32("ovf_rne",    1'b1, 32'h3F800000, 32'h00000001, 3'd0, 32'h7F800000, 5'h05, 29);
    op32("ovf_rtz",    1'b1, 32'h3F800000, 32'h00000001, 3'd1, 32'h7F7FFFFF, 5'h05, 29);
    op32("ovf_rdn",    1'b1, 32'h3F800000, 32'h00000001, 3'd2, 32'h7F7FFFFF, 5'h05, 29);
    op32("sub_exact",  1'b1, 32'h00800000, 32'h40000000, 3'd0, 32'h00400000, 5'h00, 29);
    op32("sub_tie",    1'b1, 32'h00000003, 32'h40000000, 3'd0, 32'h00000002, 5'h03, 29);

    // Back-to-back: a new request presented in the done cycle is accepted.
    op32("b2b_a",      1'b1, 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, 29);
    start32(1'b0, 32'h40800000, 32'h0, 3'd0);
    check("b2b.accepted", ready, 1'b0);
    collect32(lat);
    check("b2b.res", result, 32'h40000000);
    check("b2b.lat", lat, 29);

    // req together with flush while idle must not start an op.
    @(negedge clk);
    req = 1'b1; flush = 1'b1; is_divide = 1'b1; lhs = 32'h3F800000; rhs = 32'h40400000;
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    check("reqflush.ready", ready, 1'b1);

    // Flush mid-division: no done, ready next cycle, earlier result held.
    @(negedge clk);
    start32(1'b1, 32'h3F800000, 32'h40400000, 3'd0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.ready", ready, 1'b1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("flush.nodone", seen, 0);
    check("flush.held", result, 32'h40000000);
    op32("after_flush", 1'b1, 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, 29);

    // Asynchronous reset in the middle of ITER.
    @(negedge clk);
    start32(1'b1, 32'h3F800000, 32'h40400000, 3'd0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.ready", ready, 1'b1);
    check("arst.done", done, 1'b0);
    check("arst.result", result, 32'h0);
    check("arst.flags", fflags, 5'h0);
    @(negedge clk);
    rst = 1'b0;
    op32("after_rst", 1'b1, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01, 29);

    // Double-precision build.
    @(negedge clk);
    req_d = 1'b1; is_divide_d = 1'b1; round_mode_d = 3'd0;
    lhs_d = 64'h3FF0000000000000; rhs_d = 64'h4008000000000000;
    @(posedge clk);
    @(negedge clk);
    req_d = 1'b0;
    lat = 1;
    while (!done_d && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("dp1_3.res", result_d, 64'h3FD5555555555555);
    check("dp1_3.flags", fflags_d, 5'h01);
    check("dp1_3.lat", lat, 58);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
